layer_output_serializer: RTL and testbench
==========================================

# layer_output_serializer

Collects the per-neuron outputs of one fully-connected layer and serializes them into the single-word, contiguous stream that the next layer's neurons consume on `myInput`/`myInputValid`. It sits between layer N's neuron array and layer N+1's neuron array. It captures each neuron's `out` when that neuron's `outValid` pulses, including when the pulses arrive at different times. It double-buffers, so the next vector can be collected while the current one is streaming.

## Interface
Parameters:
- `numNeuron`, 30: number of neurons in the producing layer (≥2); equals `numWeight` of the consuming layer.
- `dataWidth`, 16: width of one activation word.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `x_valid`  in  numNeuron  bit i = `outValid` of neuron i.
- `x_in`  in  numNeuron*dataWidth  neuron i's `out` on bits [i*dataWidth +: dataWidth].
- `data_out`  out  dataWidth  serialized activation word; drives next layer's `myInput`.
- `data_out_valid`  out  1  high for exactly numNeuron consecutive cycles per vector; drives next layer's `myInputValid`.
- `data_last`  out  1  high with the final word (index numNeuron-1) of a burst.
- `busy`  out  1  high while a burst is emitting or a complete vector is pending.
- `overrun`  out  1  sticky error flag, cleared only by reset.

## Operation
- Storage: holding array `hold[numNeuron]` plus capture mask `mask[numNeuron]` (collection side); shift array `sbuf[numNeuron]` (emission side); beat counter of $clog2(numNeuron) bits; state IDLE/EMIT.
- Capture: for each i with `x_valid[i]=1` and `mask[i]=0`: `hold[i] <= x_in[i]`, `mask[i] <= 1`.
- Duplicate: `x_valid[i]=1` with `mask[i]=1` (vector not yet transferred) → value ignored, `overrun <= 1`.
- Complete condition (combinational): `(mask | x_valid) == all ones`.
- Transfer: merged vector (hold for bits already set, x_in for bits arriving this cycle) is copied into `sbuf`, and mask clears. Transfer happens when:
  - state is IDLE and complete; or
  - state is EMIT, beat = numNeuron-1, and complete.
- On transfer: state EMIT, beat ← 0.
- If complete while EMIT with beat < numNeuron-1: the vector stays in hold with mask full (pending). Any further x_valid while pending → overrun; the stored value is kept.
- EMIT: `data_out = sbuf[beat]` (neuron 0 first), `data_out_valid=1`, `data_last = (beat==numNeuron-1)`. Beat increments each cycle.
- At beat numNeuron-1 with no transfer: state → IDLE.
- IDLE: `data_out=0`, `data_out_valid=0`, `data_last=0`.
- `busy = (state==EMIT) | (mask all ones)`.
- No backpressure: the consumer must accept every beat. Words pass through unmodified; no arithmetic.

## Timing
- Reset (`rst` low, asynchronous): state IDLE, beat 0, mask 0, hold/sbuf 0. All outputs 0: `data_out`, `data_out_valid`, `data_last`, `busy`, `overrun`.
- Deassertion of reset is synchronized externally. The first capture is possible on the first edge after `rst` goes high.
- All outputs are registered.
- Latency: last `x_valid` sampled at edge E → word 0 presented in the cycle after E (1 cycle).
- Burst length: exactly numNeuron cycles, `data_out_valid` contiguous, no gaps.
- Back-to-back: if the next vector completes on or before the final beat, word 0 of the next vector directly follows word numNeuron-1. `data_out_valid` stays high with no idle cycle.
- Capture of the new vector proceeds in every cycle of a burst, including the final-beat cycle.
- Reset mid-burst: outputs drop to 0 immediately (asynchronously); partial captures and the pending vector are discarded.

## Test plan
- Reset: hold `rst` low with `x_valid` toggling → all outputs 0. Release → outputs stay 0 until a complete vector arrives.
- Simultaneous: numNeuron=4, `x_valid=4'b1111`, words 1,2,3,4 for one cycle → next 4 cycles `data_out`=1,2,3,4, `data_out_valid`=1, `data_last` on the 4th. Then IDLE, `busy`=0.
- Staggered: `x_valid` bits 2, 0, 3, 1 on separate cycles with words 0x30, 0x10, 0x40, 0x20 → burst 0x10,0x20,0x30,0x40 starts the cycle after bit 1; `busy`=0 before that.
- Back-to-back: second vector (5,6,7,8) completes while beat 2 of the first burst is shown → stream 1,2,3,4,5,6,7,8 with `data_out_valid` high for 8 consecutive cycles, `data_last` on 4 and 8.
- Overrun: during collection, `x_valid[1]` pulses twice (0xAA then 0xBB) → `overrun`=1 permanently, word 1 emitted as 0xAA. `overrun` clears only on reset.
- Async reset mid-burst: assert `rst` low between edges during beat 1 → outputs 0 before the next edge. After release, a fresh complete vector is emitted correctly with no stale words.

Source files
------------

// File: rtl/layer_output_serializer.sv
// Collects per-neuron outputs of one layer into a holding array and streams
// them word by word to the next layer, double-buffered so collection overlaps emission.
module layer_output_serializer #(
  parameter int numNeuron = 30,
  parameter int dataWidth = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeuron-1:0]           x_valid,
  input  logic [numNeuron*dataWidth-1:0] x_in,
  output logic [dataWidth-1:0]           data_out,
  output logic                           data_out_valid,
  output logic                           data_last,
  output logic                           busy,
  output logic                           overrun
);

  localparam int BW = (numNeuron > 1) ? $clog2(numNeuron) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(numNeuron - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t               state, state_n;
  logic [BW-1:0]        beat, beat_n;
  logic [numNeuron-1:0] mask, mask_n;
  logic [dataWidth-1:0] hold   [numNeuron];
  logic [dataWidth-1:0] sbuf   [numNeuron];
  logic [dataWidth-1:0] merged [numNeuron];
  logic [dataWidth-1:0] sbuf_n [numNeuron];
  logic                 complete, dup, transfer;

  always_comb begin
    complete = &(mask | x_valid);
    dup      = |(mask & x_valid);
    // A finished vector may only move to the shift array when no burst is
    // using it, or when the burst is on its final beat.
    transfer = complete && ((state == IDLE) || (beat == LAST_BEAT));
    for (int i = 0; i < numNeuron; i++) begin
      merged[i] = mask[i] ? hold[i] : x_in[i*dataWidth +: dataWidth];
      sbuf_n[i] = transfer ? merged[i] : sbuf[i];
    end
    mask_n  = transfer ? '0 : (mask | x_valid);
    state_n = state;
    beat_n  = beat;
    case (state)
      IDLE: begin
        if (transfer) begin
          state_n = EMIT;
          beat_n  = '0;
        end
      end
      EMIT: begin
        if (beat == LAST_BEAT) begin
          beat_n = '0;
          if (!transfer) state_n = IDLE;
        end else begin
          beat_n = beat + BW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        beat_n  = '0;
      end
    endcase
  end

  // State and capture registers; outputs are registered from next-state values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      beat           <= '0;
      mask           <= '0;
      overrun        <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_last      <= 1'b0;
      busy           <= 1'b0;
      for (int i = 0; i < numNeuron; i++) begin
        hold[i] <= '0;
        sbuf[i] <= '0;
      end
    end else begin
      state   <= state_n;
      beat    <= beat_n;
      mask    <= mask_n;
      overrun <= overrun | dup;
      for (int i = 0; i < numNeuron; i++) begin
        if (x_valid[i] && !mask[i]) hold[i] <= x_in[i*dataWidth +: dataWidth];
        sbuf[i] <= sbuf_n[i];
      end
      data_out_valid <= (state_n == EMIT);
      data_out       <= (state_n == EMIT) ? sbuf_n[beat_n] : '0;
      data_last      <= (state_n == EMIT) && (beat_n == LAST_BEAT);
      busy           <= (state_n == EMIT) || (&mask_n);
    end
  end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer: directed scenarios plus random capture
// traffic checked every cycle against a queue-based stream model.
module tb_layer_output_serializer;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   x_valid = '0;
  logic [N*W-1:0] x_in = '0;
  logic [W-1:0]   data_out;
  logic           data_out_valid, data_last, busy, overrun;

  int n_cmp = 0;
  int n_err = 0;

  // Model: q holds the words of the burst(s) still to be shown, front = on the bus now
  logic [W-1:0] q[$];
  logic [W-1:0] col [N];
  bit           cmask [N];
  bit           ovr;

  layer_output_serializer #(.numNeuron(N), .dataWidth(W)) dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_last(data_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit col_full();
    for (int i = 0; i < N; i++) if (!cmask[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < N; i++) begin
      col[i] = '0;
      cmask[i] = 1'b0;
    end
    ovr = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] v, input logic [N*W-1:0] d);
    if (q.size() > 0) void'(q.pop_front());
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (cmask[i]) ovr = 1'b1;
        else begin
          col[i] = d[i*W +: W];
          cmask[i] = 1'b1;
        end
      end
    end
    if (col_full() && q.size() == 0) begin
      for (int i = 0; i < N; i++) begin
        q.push_back(col[i]);
        cmask[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [W-1:0] exp_d;
    exp_d = (q.size() > 0) ? q[0] : '0;
    check({tag, ".valid"}, 32'(data_out_valid), 32'(q.size() > 0));
    check({tag, ".data"}, 32'(data_out), 32'(exp_d));
    check({tag, ".last"}, 32'(data_last), 32'(q.size() == 1));
    check({tag, ".busy"}, 32'(busy), 32'((q.size() > 0) || col_full()));
    check({tag, ".overrun"}, 32'(overrun), 32'(ovr));
  endtask

  task automatic cycle(input string tag, input logic [N-1:0] v, input logic [N*W-1:0] d);
    x_valid = v;
    x_in = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) cycle(tag, '0, $urandom);
  endtask

  initial begin
    model_clear();
    // Reset held low while inputs toggle
    for (int k = 0; k < 4; k++) begin
      x_valid = N'($urandom);
      x_in = {$urandom, $urandom};
      @(posedge clk);
      #1;
      compare_all("reset");
    end
    @(negedge clk);
    rst = 1'b1;
    idle("post_reset", 3);

    // Simultaneous capture
    cycle("simul", 4'b1111, {16'd4, 16'd3, 16'd2, 16'd1});
    idle("simul", 6);

    // Staggered capture
    cycle("stagger", 4'b0100, {16'h0, 16'h30, 16'h0, 16'h0});
    cycle("stagger", 4'b0001, {16'h0, 16'h0, 16'h0, 16'h10});
    cycle("stagger", 4'b1000, {16'h40, 16'h0, 16'h0, 16'h0});
    cycle("stagger", 4'b0010, {16'h0, 16'h0, 16'h20, 16'h0});
    idle("stagger", 6);

    // Back-to-back: second vector completes while beat 2 of the first is shown
    cycle("b2b", 4'b1111, {16'd4, 16'd3, 16'd2, 16'd1});
    cycle("b2b", 4'b0011, {16'h0, 16'h0, 16'd6, 16'd5});
    cycle("b2b", 4'b0000, '0);
    cycle("b2b", 4'b1100, {16'd8, 16'd7, 16'h0, 16'h0});
    idle("b2b", 10);

    // Duplicate capture sets sticky overrun; first value wins
    cycle("ovr", 4'b0010, {16'h0, 16'h0, 16'hAA, 16'h0});
    cycle("ovr", 4'b0010, {16'h0, 16'h0, 16'hBB, 16'h0});
    cycle("ovr", 4'b1101, {16'h3C, 16'h2C, 16'h0, 16'h1C});
    idle("ovr", 8);

    // Asynchronous reset during beat 1 of a burst
    cycle("arst", 4'b1111, {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0});
    cycle("arst", 4'b0101, {16'h0, 16'h7777, 16'h0, 16'h6666});
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    compare_all("arst_mid");
    @(negedge clk);
    rst = 1'b1;
    idle("arst_after", 2);
    cycle("arst_fresh", 4'b1111, {16'hA4, 16'hA3, 16'hA2, 16'hA1});
    idle("arst_fresh", 6);

    // Random traffic, with denser bursts to exercise pending/back-to-back paths
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < ((k < 200) ? 30 : 60));
      cycle("rand", v, {$urandom, $urandom});
    end
    idle("drain", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
